// File: rtl/serial_feeder_pkg.sv
// Parameters shared by the serial feeder and the downstream sequence detector.
`timescale 1ns/1ps
package serial_feeder_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: one bit per cycle, first bit the cycle after acceptance, words back-to-back.
// Two-word storage (shifter + pending); din_ready drops only while the pending slot is occupied.
`timescale 1ns/1ps
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int W         = DEFAULT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_valid,
  input  logic [W-1:0] din_data,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST   = CW'(W - 1);
  localparam logic [CW-1:0] PENULT = CW'(W - 2);

  state_t         state;
  state_t         next_state;
  logic [W-1:0]   shreg;
  logic [W-1:0]   pend;
  logic           pend_full;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           last_bit;
  logic           load_din;
  logic           load_pend;
  logic           advance;
  logic           capture_pend;
  logic [W-1:0]   load_word;

  function automatic logic head(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  function automatic logic [W-1:0] step(input logic [W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = ~pend_full;
  assign accept    = din_valid & ~pend_full;
  assign last_bit  = (state == SHIFT) && (cnt == LAST);
  assign load_word = load_pend ? pend : din_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (last_bit && !pend_full && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // At the last bit the pending word wins; a fresh word only loads directly when pending is empty.
  always_comb begin
    load_din     = 1'b0;
    load_pend    = 1'b0;
    advance      = 1'b0;
    capture_pend = 1'b0;
    case (state)
      IDLE: load_din = accept;
      SHIFT: begin
        if (last_bit) begin
          if (pend_full) load_pend = 1'b1;
          else           load_din  = accept;
        end else begin
          advance      = 1'b1;
          capture_pend = accept;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (next_state == SHIFT);
      if (load_din || load_pend) begin
        shreg      <= step(load_word);
        dout       <= head(load_word);
        dout_valid <= 1'b1;
        word_done  <= 1'b0;
        cnt        <= '0;
      end else if (advance) begin
        shreg      <= step(shreg);
        dout       <= head(shreg);
        dout_valid <= 1'b1;
        word_done  <= (cnt == PENULT);
        cnt        <= cnt + 1'b1;
      end else begin
        dout       <= 1'b0;
        dout_valid <= 1'b0;
        word_done  <= 1'b0;
        cnt        <= '0;
      end

      if (load_pend) begin
        pend_full <= 1'b0;
      end else if (capture_pend) begin
        pend      <= din_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Directed bench for serial_feeder: MSB-first and LSB-first instances, reset and back-to-back cases.
`timescale 1ns/1ps
module tb_serial_feeder;

  logic       clk = 1'b0;
  logic       rst;

  logic       m_vld;
  logic [7:0] m_dat;
  logic       m_rdy, m_dout, m_dv, m_wd, m_busy;

  logic       l_vld;
  logic [7:0] l_dat;
  logic       l_rdy, l_dout, l_dv, l_wd, l_busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_feeder #(.W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (m_vld),
    .din_data   (m_dat),
    .din_ready  (m_rdy),
    .dout       (m_dout),
    .dout_valid (m_dv),
    .word_done  (m_wd),
    .busy       (m_busy)
  );

  serial_feeder #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (l_vld),
    .din_data   (l_dat),
    .din_ready  (l_rdy),
    .dout       (l_dout),
    .dout_valid (l_dv),
    .word_done  (l_wd),
    .busy       (l_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  word;
    logic [15:0] stream;
    logic [2:0]  hist;
    logic [7:0]  hits;

    rst   = 1'b1;
    m_vld = 1'b0;
    m_dat = 8'h00;
    l_vld = 1'b0;
    l_dat = 8'h00;
    #2;
    check("rst din_ready", 32'(m_rdy), 32'd1);
    check("rst dout_valid", 32'(m_dv), 32'd0);
    check("rst dout", 32'(m_dout), 32'd0);
    check("rst word_done", 32'(m_wd), 32'd0);
    check("rst busy", 32'(m_busy), 32'd0);
    check("rst lsb dout_valid", 32'(l_dv), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single word 0x52, MSB first: 0,1,0,1,0,0,1,0
    word  = 8'h52;
    m_vld = 1'b1;
    m_dat = word;
    check("w52 ready", 32'(m_rdy), 32'd1);
    tick();
    m_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("w52 valid%0d", k), 32'(m_dv), 32'd1);
      check($sformatf("w52 bit%0d", k), 32'(m_dout), 32'(word[7-k]));
      check($sformatf("w52 done%0d", k), 32'(m_wd), 32'(k == 7));
      check($sformatf("w52 busy%0d", k), 32'(m_busy), 32'd1);
      tick();
    end
    check("w52 valid after", 32'(m_dv), 32'd0);
    check("w52 dout after", 32'(m_dout), 32'd0);
    check("w52 busy after", 32'(m_busy), 32'd0);
    check("w52 done after", 32'(m_wd), 32'd0);

    // LSB first, 0x01: one then seven zeros
    l_vld = 1'b1;
    l_dat = 8'h01;
    tick();
    l_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("lsb valid%0d", k), 32'(l_dv), 32'd1);
      check($sformatf("lsb bit%0d", k), 32'(l_dout), 32'(k == 0));
      check($sformatf("lsb done%0d", k), 32'(l_wd), 32'(k == 7));
      tick();
    end
    check("lsb valid after", 32'(l_dv), 32'd0);
    check("lsb busy after", 32'(l_busy), 32'd0);

    // Back-to-back 0xA5 then 0x3C with valid held until the second acceptance
    stream = 16'hA53C;
    m_vld  = 1'b1;
    m_dat  = 8'hA5;
    tick();
    m_dat = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b2b valid%0d", k), 32'(m_dv), 32'd1);
      check($sformatf("b2b bit%0d", k), 32'(m_dout), 32'(stream[15-k]));
      check($sformatf("b2b done%0d", k), 32'(m_wd), 32'((k == 7) || (k == 15)));
      check($sformatf("b2b ready%0d", k), 32'(m_rdy), 32'((k == 0) || (k >= 8)));
      tick();
      if (k == 0) m_vld = 1'b0;
    end
    check("b2b valid after", 32'(m_dv), 32'd0);
    check("b2b busy after", 32'(m_busy), 32'd0);

    // 0xC3, then 0x81 offered exactly in the last-bit cycle with pending empty
    stream = 16'hC381;
    m_vld  = 1'b1;
    m_dat  = 8'hC3;
    tick();
    m_vld = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("edge valid%0d", k), 32'(m_dv), 32'd1);
      check($sformatf("edge bit%0d", k), 32'(m_dout), 32'(stream[15-k]));
      check($sformatf("edge done%0d", k), 32'(m_wd), 32'((k == 7) || (k == 15)));
      check($sformatf("edge ready%0d", k), 32'(m_rdy), 32'd1);
      if (k == 7) begin
        m_vld = 1'b1;
        m_dat = 8'h81;
      end
      tick();
      if (k == 7) m_vld = 1'b0;
    end
    check("edge valid after", 32'(m_dv), 32'd0);
    check("edge busy after", 32'(m_busy), 32'd0);

    // Reset at bit 3 of 0xFF with 0x00 pending
    m_vld = 1'b1;
    m_dat = 8'hFF;
    tick();
    m_dat = 8'h00;
    tick();
    m_vld = 1'b0;
    check("rstmid pending ready", 32'(m_rdy), 32'd0);
    tick();
    tick();
    check("rstmid bit3", 32'(m_dout), 32'd1);
    check("rstmid valid pre", 32'(m_dv), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid valid", 32'(m_dv), 32'd0);
    check("rstmid dout", 32'(m_dout), 32'd0);
    check("rstmid busy", 32'(m_busy), 32'd0);
    check("rstmid done", 32'(m_wd), 32'd0);
    check("rstmid ready", 32'(m_rdy), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rstmid quiet valid%0d", k), 32'(m_dv), 32'd0);
      check($sformatf("rstmid quiet busy%0d", k), 32'(m_busy), 32'd0);
      tick();
    end

    // Acceptance on the first edge after reset release; 0x4A into a "010" detector
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_vld = 1'b1;
    m_dat = 8'h4A;
    tick();
    m_vld = 1'b0;
    hist  = 3'b000;
    hits  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("det valid%0d", k), 32'(m_dv), 32'd1);
      if (m_dv) begin
        hist = {hist[1:0], m_dout};
        if ((k >= 2) && (hist == 3'b010)) hits[k] = 1'b1;
      end
      tick();
    end
    // "010" completes at serial bits 3, 6 and 8
    check("det hits", 32'(hits), 32'hA4);
    check("det valid after", 32'(m_dv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
